// File: rtl/controle_execucao_if.sv
// Bundle between the phase sequencer and its surroundings: run/step/instruction in, phase and status out.
interface controle_execucao_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic [31:0]      instrucao;
    logic [3:0]       estado;
    logic             finalizado;
    logic             busy;
    logic [CNT_W-1:0] retired;
    logic             timeout;

    modport master (
        input  run, step, instrucao,
        output estado, finalizado, busy, retired, timeout
    );

    modport slave (
        output run, step, instrucao,
        input  estado, finalizado, busy, retired, timeout
    );
endinterface

// File: rtl/controle_execucao.sv
// Multicycle phase sequencer with free-run/step modes, zero-instruction halt and retired counter.
// Optional instruction-limit watchdog enabled by defining CONTROLE_WATCHDOG_EN.
module controle_execucao #(
    parameter int DELAY_EX  = 2,
    parameter int DELAY_WB  = 2,
    parameter int CNT_W     = 16,
    parameter int MAX_INSTR = 1000
) (
    input logic clk,
    input logic rst,
    controle_execucao_if.master bus
);

    typedef enum logic [3:0] {
        PH_IF     = 4'b0000,
        PH_ID     = 4'b0001,
        PH_EX     = 4'b0010,
        PH_MEM    = 4'b0011,
        PH_WB     = 4'b0100,
        PH_AUXEX  = 4'b0101,
        PH_AUXWB  = 4'b0110,
        PH_SUMPC  = 4'b1000,
        PH_FIM    = 4'b1001,
        PH_ESPERA = 4'b1010
    } estado_t;

    localparam logic [3:0] LAST_EX = 4'(DELAY_EX > 0 ? DELAY_EX - 1 : 0);
    localparam logic [3:0] LAST_WB = 4'(DELAY_WB > 0 ? DELAY_WB - 1 : 0);

`ifdef CONTROLE_WATCHDOG_EN
    localparam bit WATCH_EN = 1'b1;
`else
    localparam bit WATCH_EN = 1'b0;
`endif

    estado_t          estado, estado_next;
    logic [3:0]       cnt, cnt_next;
    logic             finalizado;
    logic [CNT_W-1:0] retired;
    logic             limit_hit;

    assign limit_hit = WATCH_EN && ((32'(retired) + 32'd1) == 32'(MAX_INSTR));

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= PH_ESPERA;
            cnt        <= 4'd0;
            finalizado <= 1'b0;
        end else begin
            estado     <= estado_next;
            cnt        <= cnt_next;
            finalizado <= finalizado | (estado_next == PH_FIM);
        end
    end

    // The settle counter runs from 0 up to DELAY-1 so the AUX phase lasts exactly DELAY cycles.
    always_comb begin
        estado_next = estado;
        cnt_next    = cnt;
        unique case (estado)
            PH_ESPERA: if (bus.run || bus.step) estado_next = PH_IF;
            PH_IF:     estado_next = PH_ID;
            PH_ID:     estado_next = (bus.instrucao == 32'd0) ? PH_FIM : PH_EX;
            PH_EX: begin
                cnt_next    = 4'd0;
                estado_next = (DELAY_EX > 0) ? PH_AUXEX : PH_MEM;
            end
            PH_AUXEX: begin
                if (cnt == LAST_EX) begin
                    estado_next = PH_MEM;
                    cnt_next    = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            PH_MEM:    estado_next = PH_WB;
            PH_WB: begin
                cnt_next    = 4'd0;
                estado_next = (DELAY_WB > 0) ? PH_AUXWB : PH_SUMPC;
            end
            PH_AUXWB: begin
                if (cnt == LAST_WB) begin
                    estado_next = PH_SUMPC;
                    cnt_next    = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            PH_SUMPC: begin
                if (limit_hit)    estado_next = PH_FIM;
                else if (bus.run) estado_next = PH_IF;
                else              estado_next = PH_ESPERA;
            end
            PH_FIM:    estado_next = PH_FIM;
            default:   estado_next = PH_ESPERA;
        endcase
    end

    // Saturating count of completed instructions; a halting zero instruction never reaches SUMPC.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (estado == PH_SUMPC && retired != {CNT_W{1'b1}}) begin
            retired <= retired + 1'b1;
        end
    end

`ifdef CONTROLE_WATCHDOG_EN
    logic timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (estado == PH_SUMPC && limit_hit) begin
            timeout <= 1'b1;
        end
    end

    assign bus.timeout = timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.estado     = estado;
    assign bus.finalizado = finalizado;
    assign bus.retired    = retired;
    assign bus.busy       = !(estado == PH_ESPERA || estado == PH_FIM);

endmodule

// File: tb/tb_controle_execucao.sv
// Scoreboard bench for controle_execucao: directed phase traces are queued as expectations and a
// negedge monitor compares them against two instances (default delays, and zero delays with CNT_W=3).
module tb_controle_execucao;

    localparam logic [3:0] S_IF = 4'h0, S_ID = 4'h1, S_EX = 4'h2, S_MEM = 4'h3, S_WB = 4'h4;
    localparam logic [3:0] S_AUXEX = 4'h5, S_AUXWB = 4'h6, S_SUMPC = 4'h8, S_FIM = 4'h9, S_ESPERA = 4'hA;

    typedef struct {
        logic [3:0] est;
        logic       run;
        logic       step;
        logic       rst;
        logic       chk;
    } vec_t;

    typedef struct {
        int          dut;
        logic [3:0]  est;
        logic        busy;
        logic        fin;
        logic [15:0] ret;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    controle_execucao_if #(.CNT_W(16)) bus_a ();
    controle_execucao_if #(.CNT_W(3))  bus_b ();

    controle_execucao #(.DELAY_EX(2), .DELAY_WB(2), .CNT_W(16), .MAX_INSTR(1000)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );

    controle_execucao #(.DELAY_EX(0), .DELAY_WB(0), .CNT_W(3), .MAX_INSTR(4)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    task automatic addV(input logic [3:0] est, input logic run, input logic step,
                        input logic rst, input logic chk);
        vec_t v;
        v.est = est; v.run = run; v.step = step; v.rst = rst; v.chk = chk;
        vecs.push_back(v);
    endtask

    task automatic addReset(input logic run);
        addV(S_ESPERA, run, 1'b0, 1'b1, 1'b0);
        addV(S_ESPERA, run, 1'b0, 1'b1, 1'b1);
    endtask

    // One full instruction trace; run_wb is the run level from WB onwards.
    task automatic addInstr(input int dex, input int dwb, input logic run,
                            input logic step_ex, input logic run_wb);
        addV(S_IF, run, 1'b0, 1'b0, 1'b1);
        addV(S_ID, run, 1'b0, 1'b0, 1'b1);
        addV(S_EX, run, step_ex, 1'b0, 1'b1);
        for (int i = 0; i < dex; i++) addV(S_AUXEX, run, 1'b0, 1'b0, 1'b1);
        addV(S_MEM, run, 1'b0, 1'b0, 1'b1);
        addV(S_WB, run_wb, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < dwb; i++) addV(S_AUXWB, run_wb, 1'b0, 1'b0, 1'b1);
        addV(S_SUMPC, run_wb, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drive(input int d, input logic run, input logic step, input logic rst,
                         input logic [31:0] ins);
        if (d == 0) begin
            bus_a.run = run; bus_a.step = step; bus_a.instrucao = ins; rst_a = rst;
        end else begin
            bus_b.run = run; bus_b.step = step; bus_b.instrucao = ins; rst_b = rst;
        end
    endtask

    // Walks the queued trace: pushes the expectation for the current cycle, then drives the inputs
    // for the coming edge. An ID followed by FIM in the trace gets a zero instruction.
    task automatic applyStimulus(input int d, input int max_ret);
        int          ret;
        exp_t        e;
        logic [31:0] ins;
        ret = 0;
        @(posedge clk); #1;
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].chk) begin
                e.dut  = d;
                e.est  = vecs[k].est;
                e.busy = !(vecs[k].est == S_ESPERA || vecs[k].est == S_FIM);
                e.fin  = (vecs[k].est == S_FIM);
                e.ret  = 16'(ret);
`ifdef CONTROLE_WATCHDOG_EN
                e.tmo  = (d == 1) && (vecs[k].est == S_FIM);
`else
                e.tmo  = 1'b0;
`endif
                sb.push_back(e);
            end
            ins = 32'd0;
            if (vecs[k].est == S_ID) begin
                if (!(k + 1 < vecs.size() && vecs[k+1].est == S_FIM))
                    ins = 32'h00A00093 + 32'(k << 7);
            end
            drive(d, vecs[k].run, vecs[k].step, vecs[k].rst, ins);
            @(posedge clk); #1;
            if (vecs[k].rst) ret = 0;
            else if (vecs[k].est == S_SUMPC && ret < max_ret) ret++;
        end
        vecs.delete();
    endtask

    task automatic cmp(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.dut == 0) begin
            cmp("estado", 0, {12'd0, bus_a.estado}, {12'd0, e.est});
            cmp("busy", 0, {15'd0, bus_a.busy}, {15'd0, e.busy});
            cmp("final", 0, {15'd0, bus_a.finalizado}, {15'd0, e.fin});
            cmp("retired", 0, bus_a.retired, e.ret);
            cmp("timeout", 0, {15'd0, bus_a.timeout}, {15'd0, e.tmo});
        end else begin
            cmp("estado", 1, {12'd0, bus_b.estado}, {12'd0, e.est});
            cmp("busy", 1, {15'd0, bus_b.busy}, {15'd0, e.busy});
            cmp("final", 1, {15'd0, bus_b.finalizado}, {15'd0, e.fin});
            cmp("retired", 1, {13'd0, bus_b.retired}, e.ret);
            cmp("timeout", 1, {15'd0, bus_b.timeout}, {15'd0, e.tmo});
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.run = 1'b0; bus_a.step = 1'b0; bus_a.instrucao = 32'd0;
        bus_b.run = 1'b0; bus_b.step = 1'b0; bus_b.instrucao = 32'd0;

        // Free-run, default delays: three instructions then a zero instruction halts.
        addReset(1'b1);
        addV(S_ESPERA, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) addInstr(2, 2, 1'b1, 1'b0, 1'b1);
        addV(S_IF, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_ID, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b1, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 65535);

        // Step mode: one pulse gives one instruction; a pulse during EX is ignored.
        addReset(1'b0);
        addV(S_ESPERA, 1'b0, 1'b0, 1'b0, 1'b1);
        addV(S_ESPERA, 1'b0, 1'b1, 1'b0, 1'b1);
        addInstr(2, 2, 1'b0, 1'b1, 1'b0);
        repeat (3) addV(S_ESPERA, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 65535);

        // Run dropped in WB, reset in MEM, reset out of FIM.
        addReset(1'b1);
        addV(S_ESPERA, 1'b1, 1'b0, 1'b0, 1'b1);
        addInstr(2, 2, 1'b1, 1'b0, 1'b0);
        addV(S_ESPERA, 1'b0, 1'b0, 1'b0, 1'b1);
        addV(S_ESPERA, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_IF, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_ID, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_EX, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_AUXEX, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_AUXEX, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_MEM, 1'b1, 1'b0, 1'b1, 1'b1);
        addV(S_ESPERA, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_IF, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_ID, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b0, 1'b1, 1'b1);
        addV(S_ESPERA, 1'b0, 1'b0, 1'b0, 1'b1);
        addV(S_ESPERA, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 65535);

        // Zero delays and a 3-bit counter.
        addReset(1'b1);
        addV(S_ESPERA, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef CONTROLE_WATCHDOG_EN
        repeat (4) addInstr(0, 0, 1'b1, 1'b0, 1'b1);
        repeat (3) addV(S_FIM, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        repeat (9) addInstr(0, 0, 1'b1, 1'b0, 1'b1);
        addV(S_IF, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_ID, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b0, 1'b0, 1'b1);
        addV(S_FIM, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
        applyStimulus(1, 7);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
